// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit that feeds the HI/LO pair:
// operand width, operation encodings, FSM state encodings and small decode
// helpers used by the unit and its interface.
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam int WIDTH = 32;

    // Operation encodings as presented on the op bus
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Signed ops are the even encodings (MULT, DIV)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Divide ops have the upper encoding bit set
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_unit_if
// Request/response bundle between the ID/EX operand path (master) and the
// multiply/divide unit (slave).
//   start, op, a, b, flush      : master -> unit (launch, opcode, operands, kill)
//   busy, done                  : unit -> master (stall, one-cycle completion)
//   hi_we, lo_we                : unit -> HI/LO registers (write strobes)
//   hi_wdata, lo_wdata          : unit -> HI/LO registers (write data)
// ---------------------------------------------------------------------------
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = mdu_pkg::WIDTH
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi_we, lo_we, hi_wdata, lo_wdata
    );

endinterface

// File: rtl/mdu_sign_fix.sv
// ---------------------------------------------------------------------------
// mdu_sign_fix
// Combinational two's-complement negation stage used on both sides of the
// unsigned iterative core.
//   i_hi, i_lo  : upper / lower halves of the value to fix
//   i_joint     : 1 = treat {i_hi,i_lo} as one double-width value (product)
//                 0 = treat the halves independently (operands, rem/quot)
//   i_neg_hi    : negate the upper half (independent mode only)
//   i_neg_lo    : negate the lower half, or the whole value in joint mode
//   o_hi, o_lo  : fixed halves
// Pre-sign use: halves are a and b, flags are their sign bits -> |a|, |b|.
// Post-sign use: halves are the core result, flags were latched at launch.
// ---------------------------------------------------------------------------
module mdu_sign_fix #(
    parameter int WIDTH = mdu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic             i_joint,
    input  logic             i_neg_hi,
    input  logic             i_neg_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int DW = 2 * WIDTH;

    logic [DW-1:0]    w_cat;
    logic [DW-1:0]    w_cat_neg;
    logic [WIDTH-1:0] w_hi_neg;
    logic [WIDTH-1:0] w_lo_neg;

    assign w_cat     = {i_hi, i_lo};
    assign w_cat_neg = ~w_cat + {{(DW-1){1'b0}}, 1'b1};
    assign w_hi_neg  = ~i_hi + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_lo_neg  = ~i_lo + {{(WIDTH-1){1'b0}}, 1'b1};

    // Select negated or pass-through halves; the carry between halves only
    // matters for the joint (64-bit product) case.
    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        if (i_joint) begin
            if (i_neg_lo) begin
                o_hi = w_cat_neg[DW-1:WIDTH];
                o_lo = w_cat_neg[WIDTH-1:0];
            end else begin
                o_hi = i_hi;
                o_lo = i_lo;
            end
        end else begin
            if (i_neg_hi) begin
                o_hi = w_hi_neg;
            end else begin
                o_hi = i_hi;
            end
            if (i_neg_lo) begin
                o_lo = w_lo_neg;
            end else begin
                o_lo = i_lo;
            end
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_unit
// Iterative MULT/MULTU/DIV/DIVU unit producing one 64-bit HI/LO result per
// operation, one radix-2 step per clock (shift-add multiply, restoring
// divide) on magnitudes, with the sign applied when the result is written.
// Ports:
//   i_clk  : clock, all state changes on posedge
//   i_rst  : asynchronous active-high reset
//   bus    : slave side of muldiv_hilo_unit_if (start/op/a/b/flush in,
//            busy/done/hi_we/lo_we/hi_wdata/lo_wdata out)
// Timing: start sampled in IDLE at edge E0; result registered at E32 and
// presented with done/hi_we/lo_we for the single cycle E32..E33. A divide by
// zero skips RUN and completes at E0 with hi=a, lo=all ones.
// ---------------------------------------------------------------------------
module muldiv_hilo_unit #(
    parameter int WIDTH = mdu_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    muldiv_hilo_unit_if.slave bus
);

    import mdu_pkg::*;

    localparam int DW = 2 * WIDTH;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_acc;       // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0] r_opnd;      // MUL: multiplicand; DIV: divisor
    logic             r_is_mul;
    logic             r_neg_hi;
    logic             r_neg_lo;
    logic [WIDTH-1:0] r_hi_wdata;
    logic [WIDTH-1:0] r_lo_wdata;

    logic             w_signed;
    logic             w_is_div;
    logic             w_launch;
    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [DW-1:0]    w_mul_next;
    logic [WIDTH:0]   w_div_trial;
    logic [DW-1:0]    w_div_next;
    logic [DW-1:0]    w_acc_next;
    logic [WIDTH-1:0] w_post_hi;
    logic [WIDTH-1:0] w_post_lo;

    assign w_signed   = op_is_signed(bus.op);
    assign w_is_div   = op_is_div(bus.op);
    assign w_launch   = bus.start & ~bus.flush;
    assign w_div_zero = w_is_div & (bus.b == {WIDTH{1'b0}});
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Operand magnitudes for signed ops; raw operands otherwise
    mdu_sign_fix #(.WIDTH(WIDTH)) u_pre_sign (
        .i_hi     (bus.a),
        .i_lo     (bus.b),
        .i_joint  (1'b0),
        .i_neg_hi (w_signed & bus.a[WIDTH-1]),
        .i_neg_lo (w_signed & bus.b[WIDTH-1]),
        .o_hi     (w_abs_a),
        .o_lo     (w_abs_b)
    );

    // Shift-add multiply step: add multiplicand when the multiplier LSB is set,
    // then shift the whole accumulator right with the carry out on top.
    assign w_mul_sum  = {1'b0, r_acc[DW-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: trial-subtract divisor from the remainder shifted
    // left by one with the next dividend bit. The dropped top bit can only be
    // set when the trial succeeds, so the kept remainder still fits WIDTH bits.
    assign w_div_trial = r_acc[DW-1:WIDTH-1] - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? {r_acc[DW-2:WIDTH-1], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_acc_next = r_is_mul ? w_mul_next : w_div_next;

    // Result sign: whole product for MULT, quotient/remainder separately for DIV
    mdu_sign_fix #(.WIDTH(WIDTH)) u_post_sign (
        .i_hi     (w_acc_next[DW-1:WIDTH]),
        .i_lo     (w_acc_next[WIDTH-1:0]),
        .i_joint  (r_is_mul),
        .i_neg_hi (r_neg_hi),
        .i_neg_lo (r_neg_lo),
        .o_hi     (w_post_hi),
        .o_lo     (w_post_lo)
    );

    // Control FSM, iteration counter, datapath and registered result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_acc      <= {DW{1'b0}};
            r_opnd     <= {WIDTH{1'b0}};
            r_is_mul   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_hi_wdata <= {WIDTH{1'b0}};
            r_lo_wdata <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        if (w_div_zero) begin
                            r_state    <= S_DONE;
                            r_hi_wdata <= bus.a;
                            r_lo_wdata <= {WIDTH{1'b1}};
                        end else begin
                            r_state  <= S_RUN;
                            r_cnt    <= {CNT_W{1'b0}};
                            r_is_mul <= ~w_is_div;
                            r_neg_lo <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            // DIV remainder follows the dividend; MULT uses r_neg_lo only
                            r_neg_hi <= w_signed & bus.a[WIDTH-1];
                            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (w_last) begin
                            r_state    <= S_DONE;
                            r_hi_wdata <= w_post_hi;
                            r_lo_wdata <= w_post_lo;
                        end else begin
                            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.hi_we    = (r_state == S_DONE);
    assign bus.lo_we    = (r_state == S_DONE);
    assign bus.hi_wdata = r_hi_wdata;
    assign bus.lo_wdata = r_lo_wdata;

endmodule
